// File: rtl/mem_bus_interface.sv
// Memory-side bus bridge: turns core MemRead/MemWrite strobes into a req/ack
// bus transaction, stalls the core meanwhile and captures read data (MDR).
//
// state   | meaning
// S_IDLE  | no access outstanding; a legal strobe starts a request
// S_WAIT  | BusReq held, waiting for BusAck or timeout
// S_DONE  | one-cycle completion, Stall low so the core advances
// S_FAULT | terminal fault, Stall and Fault held until Rst
module mem_bus_interface #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              Stall,
  output logic              Fault,
  output logic              BusReq,
  output logic              BusWe,
  output logic [ADDR_W-1:0] BusAddr,
  output logic [DATA_W-1:0] BusWData,
  input  logic [DATA_W-1:0] BusRData,
  input  logic              BusAck
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_FAULT} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  logic             w_access;
  logic             w_illegal;
  logic [CNT_W-1:0] w_cnt_next;

  assign w_access   = MemRead | MemWrite;
  assign w_illegal  = (MemRead & MemWrite) | (w_access & (Addr[1:0] != 2'b00));
  assign w_cnt_next = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CNT_ONE;

  assign Stall = !Rst && (((r_state == S_IDLE) && w_access) ||
                          (r_state == S_WAIT) || (r_state == S_FAULT));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      BusReq   <= 1'b0;
      BusWe    <= 1'b0;
      BusAddr  <= '0;
      BusWData <= '0;
      ReadData <= '0;
      Fault    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            if (w_illegal) begin
              Fault   <= 1'b1;
              r_state <= S_FAULT;
            end else begin
              BusAddr  <= {Addr[ADDR_W-1:2], 2'b00};
              BusWData <= WriteData;
              BusWe    <= MemWrite;
              BusReq   <= 1'b1;
              r_cnt    <= '0;
              r_state  <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // Ack takes priority over a timeout landing in the same cycle
          if (BusAck) begin
            BusReq <= 1'b0;
            if (!BusWe) ReadData <= BusRData;
            r_state <= S_DONE;
          end else begin
            r_cnt <= w_cnt_next;
            if (w_cnt_next == CNT_MAX) begin
              BusReq  <= 1'b0;
              Fault   <= 1'b1;
              r_state <= S_FAULT;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        S_FAULT: r_state <= S_FAULT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_bus_interface.md
# mem_bus_interface

Memory-side bridge for the multi-cycle core. It sits downstream of the control unit and consumes its MemRead/MemWrite strobes together with the datapath address and write data. It runs a request/acknowledge transaction on an external memory bus that can have variable latency. It holds the core in place through Stall until the access completes, and it captures read data into a holding register (the memory data register) that feeds IR and the MemToReg mux.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 16, max WAIT cycles without BusAck before fault (≥1)
- Clk  input  1  clock; all state updates on rising edge
- Rst  input  1  reset, synchronous, active-high; clock Clk
- MemRead  input  1  read strobe from control unit
- MemWrite  input  1  write strobe from control unit
- Addr  input  ADDR_W  byte address (IorD mux output)
- WriteData  input  DATA_W  store data (register B)
- ReadData  output  DATA_W  registered read data (MDR)
- Stall  output  1  hold PC/IR/PS updates while high
- Fault  output  1  sticky bus/access fault
- BusReq  output  1  registered request, held until BusAck
- BusWe  output  1  1 = write, valid while BusReq
- BusAddr  output  ADDR_W  registered, word-aligned address
- BusWData  output  DATA_W  registered write data
- BusRData  input  DATA_W  read data, valid with BusAck
- BusAck  input  1  single-cycle completion pulse

## Operation
- Access = MemRead | MemWrite. Illegal = both strobes high, or Addr[1:0] ≠ 0 while Access is high.
- States: IDLE, WAIT, DONE, FAULT.
- IDLE, no Access: remain in IDLE.
- IDLE, legal Access: latch Addr, WriteData and MemWrite into BusAddr, BusWData and BusWe. Set BusReq to 1. Clear the timeout counter. Go to WAIT.
- IDLE, illegal Access: set Fault. Go to FAULT. No bus request is issued.
- WAIT, BusAck sampled high: clear BusReq. On a read, latch BusRData into ReadData. Go to DONE.
- WAIT, no BusAck: increment the counter. When the counter reaches TIMEOUT, clear BusReq, set Fault and go to FAULT.
- BusAck wins over timeout in the same cycle.
- DONE: lasts one cycle with Stall low, so the core advances at the end of this cycle. Strobes are ignored in DONE because the core still presents the old strobe. Return to IDLE.
- FAULT: terminal. Stall is held at 1 and Fault at 1 until Rst.
- Stall is combinational: (IDLE & Access) | WAIT | FAULT. It is forced to 0 while Rst is high.
- ReadData holds its value until the next completed read. Writes never modify ReadData.
- BusAck outside WAIT is spurious and ignored. It changes no state and no outputs.
- Counter width is $clog2(TIMEOUT+1) bits. The counter saturates and does not wrap.

## Timing
- Reset values: state IDLE, BusReq 0, BusWe 0, BusAddr 0, BusWData 0, ReadData 0, Fault 0, counter 0, Stall 0.
- Rst mid-transaction: on the next edge, everything returns to reset values and BusReq drops. Any BusAck arriving afterwards is ignored.
- BusAddr, BusWData and BusWe are stable from the cycle BusReq rises until the cycle after BusAck.
- Minimum access timeline:
  - Cycle 0: strobe in IDLE, Stall 1.
  - Cycle 1: WAIT with BusReq 1. BusAck may arrive in this cycle.
  - Cycle 2: DONE with Stall 0 and ReadData valid.
  - Result: 3 cycles per access, 2 of them stalled.
- Each extra cycle of bus latency adds one stalled cycle.
- Timeout: Fault rises on the edge after the TIMEOUT-th consecutive WAIT cycle with no BusAck.
- Back-to-back accesses (e.g., a read in the state after fetch): the new request is accepted in the IDLE cycle after DONE. There is never more than one outstanding request.

## Test plan
- Read, zero wait: Addr=0x100, MemRead=1; BusAck with BusRData=0xDEADBEEF in the first WAIT cycle.
  - Required: BusReq high for 1 cycle, Stall high for 2 cycles.
  - Required: ReadData=0xDEADBEEF in DONE, Stall 0 in DONE.
- Write, 3-cycle latency: Addr=0x204, WriteData=0x12345678.
  - Required: BusWe=1 and bus fields stable for 3 cycles, Stall high for 4 cycles.
  - Required: ReadData unchanged.
- Timeout: TIMEOUT=4, never ack.
  - Required: BusReq drops and Fault=1 after 4 WAIT cycles.
  - Required: Stall stays 1, and a later BusAck has no effect.
- Ack on the boundary: BusAck arrives exactly on the 4th WAIT cycle with TIMEOUT=4.
  - Required: completes normally to DONE, Fault stays 0.
- Illegal accesses: Addr=0x102 with MemRead, and separately MemRead=MemWrite=1.
  - Required: Fault=1 next cycle, BusReq never asserted.
- Reset mid-WAIT, then a spurious BusAck.
  - Required: all outputs return to reset values, state IDLE, ReadData=0, no DONE cycle.
